arbiter_rr_n: RTL and testbench

//  Shares one dynamic (latency-insensitive) memory port among NUM_PORTS requesters, each with read and write.

---
 rtl/arbiter_pkg.sv | 30 +++
 rtl/arbiter_rr_n_if.sv | 42 ++++
 rtl/arbiter_rr_n_rr_pick.sv | 26 ++
 rtl/arbiter_rr_n.sv | 125 ++++++++++++
 tb/tb_arbiter_rr_n.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for round-robin memory arbiters.
// Holds the FSM state type and the rotating-priority pick function.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  localparam int ARB_MAX_PORTS = 32;

  // First set bit of req scanning ptr+1, ptr+2, ... (mod n).
  // Returns -1 when nothing is requesting.
  function automatic int rr_next(
    input logic [ARB_MAX_PORTS-1:0] req,
    input int                       n,
    input int                       ptr
  );
    int idx;
    rr_next = -1;
    // Walk from the farthest slot back so the nearest one wins.
    for (int k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      if (req[idx])
        rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/arbiter_rr_n_if.sv
// Bundle between N requesters, the arbiter and one dynamic memory.
// slave: arbiter view; master: requesters plus memory (bench side).
interface arbiter_rr_n_if #(
  parameter int WIDTH     = 32,
  parameter int IDX_SIZE  = 4,
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2
) ();

  logic [NUM_PORTS*IDX_SIZE-1:0] addr;
  logic [NUM_PORTS*WIDTH-1:0]    in;
  logic [NUM_PORTS-1:0]          read_en;
  logic [NUM_PORTS-1:0]          write_en;
  logic [NUM_PORTS*WIDTH-1:0]    out;
  logic [NUM_PORTS-1:0]          read_done;
  logic [NUM_PORTS-1:0]          write_done;
  logic [PORT_BITS-1:0]          grant;
  logic                          busy;

  logic [IDX_SIZE-1:0]           mem_addr;
  logic [WIDTH-1:0]              mem_in;
  logic                          mem_read_en;
  logic                          mem_write_en;
  logic [WIDTH-1:0]              mem_out;
  logic                          mem_read_done;
  logic                          mem_write_done;

  modport slave (
    input  addr, in, read_en, write_en,
    input  mem_out, mem_read_done, mem_write_done,
    output out, read_done, write_done, grant, busy,
    output mem_addr, mem_in, mem_read_en, mem_write_en
  );

  modport master (
    output addr, in, read_en, write_en,
    output mem_out, mem_read_done, mem_write_done,
    input  out, read_done, write_done, grant, busy,
    input  mem_addr, mem_in, mem_read_en, mem_write_en
  );

endinterface

// File: rtl/arbiter_rr_n_rr_pick.sv
// Combinational round-robin picker: req vector + last winner -> next.
// Ports: req, ptr in; valid (any req), idx (winner) out.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 valid,
  output logic [PORT_BITS-1:0] idx
);

  logic [ARB_MAX_PORTS-1:0] req_w;
  int                       p;

  always_comb begin
    req_w                = '0;
    req_w[NUM_PORTS-1:0] = req;
    p     = rr_next(req_w, NUM_PORTS, int'(ptr));
    valid = (p >= 0);
    idx   = valid ? PORT_BITS'(p) : '0;
  end

endmodule

// File: rtl/arbiter_rr_n.sv
// Round-robin share of one dynamic memory port among NUM_PORTS users.
// Ports: clk, reset (sync, high), bus (arbiter_rr_n_if.slave).
module arbiter_rr_n
  import arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 16,
  parameter int IDX_SIZE  = 4,
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = 2
) (
  input logic          clk,
  input logic          reset,
  arbiter_rr_n_if.slave bus
);

  if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_bad_n
    $error("arbiter_rr_n: NUM_PORTS out of range");
  end
  if (SIZE > (1 << IDX_SIZE)) begin : g_bad_size
    $error("arbiter_rr_n: SIZE exceeds address space");
  end

  logic [IDX_SIZE-1:0]  addr_a [NUM_PORTS];
  logic [WIDTH-1:0]     in_a   [NUM_PORTS];
  logic [WIDTH-1:0]     out_q  [NUM_PORTS];

  arb_state_t           state_q;
  logic [PORT_BITS-1:0] ptr_q;
  logic [PORT_BITS-1:0] grant_q;
  logic                 kind_wr_q;
  logic                 busy_q;
  logic [NUM_PORTS-1:0] rd_done_q;
  logic [NUM_PORTS-1:0] wr_done_q;
  logic [IDX_SIZE-1:0]  mem_addr_q;
  logic [WIDTH-1:0]     mem_in_q;
  logic                 mem_rd_q;
  logic                 mem_wr_q;

  logic [NUM_PORTS-1:0] req;
  logic                 pick_valid;
  logic [PORT_BITS-1:0] pick;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign addr_a[i] = bus.addr[i*IDX_SIZE +: IDX_SIZE];
    assign in_a[i]   = bus.in[i*WIDTH +: WIDTH];
    assign bus.out[i*WIDTH +: WIDTH] = out_q[i];
  end

  assign req = bus.read_en | bus.write_en;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= PORT_BITS'(NUM_PORTS - 1);
      grant_q    <= '0;
      kind_wr_q  <= 1'b0;
      busy_q     <= 1'b0;
      rd_done_q  <= '0;
      wr_done_q  <= '0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
        out_q[i] <= '0;
    end else begin
      rd_done_q <= '0;
      wr_done_q <= '0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            // Write wins when a port asks for both; its
            // read stays pending for a later grant.
            grant_q    <= pick;
            ptr_q      <= pick;
            mem_addr_q <= addr_a[pick];
            mem_in_q   <= in_a[pick];
            kind_wr_q  <= bus.write_en[pick];
            mem_wr_q   <= bus.write_en[pick];
            mem_rd_q   <= ~bus.write_en[pick];
            busy_q     <= 1'b1;
            state_q    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (kind_wr_q && bus.mem_write_done) begin
            mem_wr_q           <= 1'b0;
            wr_done_q[grant_q] <= 1'b1;
            busy_q             <= 1'b0;
            state_q            <= ARB_RESP;
          end else if (!kind_wr_q && bus.mem_read_done) begin
            mem_rd_q           <= 1'b0;
            out_q[grant_q]     <= bus.mem_out;
            rd_done_q[grant_q] <= 1'b1;
            busy_q             <= 1'b0;
            state_q            <= ARB_RESP;
          end
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;
  assign bus.read_done    = rd_done_q;
  assign bus.write_done   = wr_done_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_in       = mem_in_q;
  assign bus.mem_read_en  = mem_rd_q;
  assign bus.mem_write_en = mem_wr_q;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Randomized bench for arbiter_rr_n against a transaction-level model.
// Bench plays both the requesters and the memory behind the arbiter.
module tb_arbiter_rr_n;

  localparam int W   = 32;
  localparam int SZ  = 16;
  localparam int IDX = 4;
  localparam int N   = 4;
  localparam int PB  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbiter_rr_n_if #(
    .WIDTH(W), .IDX_SIZE(IDX), .NUM_PORTS(N), .PORT_BITS(PB)
  ) bus ();

  arbiter_rr_n #(
    .WIDTH(W), .SIZE(SZ), .IDX_SIZE(IDX),
    .NUM_PORTS(N), .PORT_BITS(PB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mem_m [SZ];
  logic [W-1:0] out_m [N];
  int           ptr_m;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_bus();
    bus.addr           = '0;
    bus.in             = '0;
    bus.read_en        = '0;
    bus.write_en       = '0;
    bus.mem_out        = '0;
    bus.mem_read_done  = 1'b0;
    bus.mem_write_done = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    for (int j = 0; j < N; j++)
      chk($sformatf("%s_out%0d", tag, j),
          bus.out[j*W +: W], out_m[j]);
  endtask

  function automatic int exp_pick();
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr_m + k) % N;
      if (bus.read_en[idx] || bus.write_en[idx])
        return idx;
    end
    return -1;
  endfunction

  function automatic bit any_req();
    return (bus.read_en | bus.write_en) != '0;
  endfunction

  task automatic model_reset();
    ptr_m = N - 1;
    for (int j = 0; j < N; j++)
      out_m[j] = '0;
  endtask

  // Called in the first BUSY cycle of a transaction; returns in
  // the IDLE cycle that follows its RESP cycle.
  task automatic serve_one();
    int             p;
    bit             wr;
    int             dly;
    logic [IDX-1:0] a;
    logic [W-1:0]   d;
    logic [N-1:0]   rdv;
    logic [N-1:0]   wrv;
    p = exp_pick();
    if (p < 0) begin
      chk("pick_exists", 1'b0, 1'b1);
      return;
    end
    wr  = bus.write_en[p];
    a   = bus.addr[p*IDX +: IDX];
    d   = bus.in[p*W +: W];
    dly = $urandom_range(0, 5);
    chk("grant", bus.grant, p);
    chk("busy", bus.busy, 1);
    chk("mem_en", {bus.mem_write_en, bus.mem_read_en},
        {wr, !wr});
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_in", bus.mem_in, d);
    repeat (dly) begin
      bus.mem_read_done  = wr & 1'($urandom_range(0, 1));
      bus.mem_write_done = !wr & 1'($urandom_range(0, 1));
      bus.mem_out        = $urandom;
      tick();
      chk("hold_grant", bus.grant, p);
      chk("hold_addr", bus.mem_addr, a);
      chk("hold_in", bus.mem_in, d);
      chk("hold_en", {bus.mem_write_en, bus.mem_read_en},
          {wr, !wr});
      chk("no_done", {bus.read_done, bus.write_done}, 0);
    end
    bus.mem_read_done  = !wr;
    bus.mem_write_done = wr;
    bus.mem_out        = wr ? W'($urandom) : mem_m[a];
    tick();
    bus.mem_read_done  = 1'b0;
    bus.mem_write_done = 1'b0;
    rdv = '0;
    wrv = '0;
    if (wr) begin
      wrv[p]         = 1'b1;
      mem_m[a]       = d;
      bus.write_en[p] = 1'b0;
    end else begin
      rdv[p]         = 1'b1;
      out_m[p]       = mem_m[a];
      bus.read_en[p] = 1'b0;
    end
    ptr_m = p;
    chk("read_done", bus.read_done, rdv);
    chk("write_done", bus.write_done, wrv);
    chk("resp_busy", bus.busy, 0);
    chk("resp_en", {bus.mem_write_en, bus.mem_read_en}, 0);
    check_outs("resp");
    bus.mem_read_done  = 1'($urandom_range(0, 1));
    bus.mem_write_done = 1'($urandom_range(0, 1));
    bus.mem_out        = $urandom;
    tick();
    chk("idle_done", {bus.read_done, bus.write_done}, 0);
    chk("idle_en", {bus.mem_write_en, bus.mem_read_en}, 0);
    check_outs("idle");
    bus.mem_read_done  = 1'($urandom_range(0, 1));
    bus.mem_write_done = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (any_req() && guard < 4 * N) begin
      tick();
      serve_one();
      guard++;
    end
    chk("drained", any_req(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_done"}, {bus.read_done, bus.write_done}, 0);
    chk({tag, "_mem_en"},
        {bus.mem_write_en, bus.mem_read_en}, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_in"}, bus.mem_in, 0);
    check_outs(tag);
  endtask

  initial begin
    for (int i = 0; i < SZ; i++)
      mem_m[i] = $urandom;
    quiet_bus();
    model_reset();
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("rst");
    reset = 1'b0;

    // All ports read from reset: grants go 0,1,2,3.
    for (int i = 0; i < N; i++) begin
      bus.addr[i*IDX +: IDX] = IDX'(i + 5);
      bus.read_en[i]         = 1'b1;
    end
    drain();

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        int kind;
        kind = $urandom_range(0, 3);
        bus.addr[i*IDX +: IDX] = IDX'($urandom_range(0, SZ - 1));
        bus.in[i*W +: W]       = $urandom;
        bus.read_en[i]         = kind[0];
        bus.write_en[i]        = kind[1];
      end
      if (!any_req()) begin
        tick();
        chk("no_req_busy", bus.busy, 0);
        check_outs("no_req");
      end
      drain();
    end

    // Reset while a write is outstanding.
    for (int i = 0; i < N; i++) begin
      bus.addr[i*IDX +: IDX] = IDX'(i);
      bus.in[i*W +: W]       = $urandom;
      bus.write_en[i]        = 1'b1;
    end
    bus.mem_read_done  = 1'b0;
    bus.mem_write_done = 1'b0;
    tick();
    chk("pre_rst_busy", bus.busy, 1);
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    check_reset_state("mid_rst");
    reset = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
